// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: multi-operand add sequencer.
// It drives one shared external 32-bit adder. Operands arrive one per cycle
// over a valid/ready handshake. The carries out of bit 31 are counted in a
// small accumulator, so the full sum is returned without truncation.
module add_seq_ctrl #(
  parameter int MAX_OPS = 5,
  parameter int CW      = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [2:0]    num_ops,
  input  logic          cin,
  input  logic          abort,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [31:0]   op_data,
  output logic [31:0]   add_a,
  output logic [31:0]   add_b,
  output logic          add_cin,
  input  logic [31:0]   add_result,
  input  logic          add_cout,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   result,
  output logic [CW-1:0] result_hi,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [2:0] MAX_N = 3'(MAX_OPS);

  state_t        state, state_next;
  logic [31:0]   acc;
  logic [CW-1:0] hi;
  logic [CW-1:0] hi_sum;
  logic [2:0]    remaining;
  logic          cin_l;
  logic          first;
  logic          legal;
  logic          start_ok;
  logic          xfer;
  logic          last_xfer;

  // abort in IDLE suppresses a same-cycle start entirely, including err
  assign legal     = (num_ops != 3'd0) && (num_ops <= MAX_N);
  assign start_ok  = (state == IDLE) && start && !abort;
  assign xfer      = (state == ACCUM) && op_valid && !abort;
  assign last_xfer = xfer && (remaining == 3'd1);
  assign hi_sum    = hi + CW'(add_cout);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state and output decode; abort takes priority over both handshakes
  always_comb begin
    state_next = state;
    op_ready   = 1'b0;
    res_valid  = 1'b0;
    busy       = (state != IDLE);
    add_a      = acc;
    add_b      = 32'd0;
    add_cin    = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok && legal) state_next = ACCUM;
      end
      ACCUM: begin
        op_ready = 1'b1;
        add_b    = op_data;
        add_cin  = first ? cin_l : 1'b0;
        if (abort)          state_next = IDLE;
        else if (last_xfer) state_next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (abort || res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job datapath; the result registers capture the final sum on the last
  // transfer so they stay put after the job returns to IDLE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc       <= 32'd0;
      hi        <= '0;
      remaining <= 3'd0;
      cin_l     <= 1'b0;
      first     <= 1'b0;
      result    <= 32'd0;
      result_hi <= '0;
      err       <= 1'b0;
    end else begin
      err <= start_ok && !legal;
      if (start_ok && legal) begin
        acc       <= 32'd0;
        hi        <= '0;
        remaining <= num_ops;
        cin_l     <= cin;
        first     <= 1'b1;
      end
      if (xfer) begin
        acc       <= add_result;
        hi        <= hi_sum;
        first     <= 1'b0;
        remaining <= remaining - 3'd1;
        if (last_xfer) begin
          result    <= add_result;
          result_hi <= hi_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed testbench for add_seq_ctrl with a behavioural shared adder.
module tb_add_seq_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start, cin, abort, op_valid, res_ready;
  logic [2:0]  num_ops;
  logic [31:0] op_data;
  logic        op_ready, res_valid, busy, err, add_cin, add_cout;
  logic [31:0] add_a, add_b, add_result, result;
  logic [2:0]  result_hi;
  logic [32:0] sum;

  int errors = 0;
  int checks = 0;

  add_seq_ctrl #(.MAX_OPS(5), .CW(3)) dut (
    .clk(clk), .resetn(resetn), .start(start), .num_ops(num_ops), .cin(cin),
    .abort(abort), .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_result(add_result),
    .add_cout(add_cout), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .result_hi(result_hi), .busy(busy), .err(err)
  );

  // The external shared adder
  assign sum        = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
  assign add_result = sum[31:0];
  assign add_cout   = sum[32];

  // Free-running clock
  always #5 clk = ~clk;

  // Global watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] n, input logic c,
                               input logic v, input logic [31:0] d,
                               input logic rr, input logic ab);
    start = s; num_ops = n; cin = c; op_valid = v; op_data = d;
    res_ready = rr; abort = ab;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a job: start is sampled on the next edge
  task automatic startJob(input logic [2:0] n, input logic c);
    applyStimulus(1'b1, n, c, 1'b0, 32'd0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic sendOp(input logic [31:0] d);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, d, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic drainResult();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  // Linear directed sequence
  initial begin
    resetn = 1'b0;
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b1, 32'h5, 1'b1, 1'b0);
    repeat (3) step();
    checkOutput("rst_op_ready", op_ready, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_result_hi", result_hi, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    resetn = 1'b1;
    step();
    checkOutput("post_rst_op_ready", op_ready, 0);
    checkOutput("post_rst_res_valid", res_valid, 0);

    $display("[TB] basic two-operand job");
    startJob(3'd2, 1'b1);
    checkOutput("basic_busy", busy, 1);
    checkOutput("basic_op_ready", op_ready, 1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 32'h5, 1'b0, 1'b0);
    checkOutput("basic_cin_first", add_cin, 1);
    checkOutput("basic_add_b", add_b, 32'h5);
    step();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 32'h7, 1'b0, 1'b0);
    checkOutput("basic_cin_second", add_cin, 0);
    checkOutput("basic_add_a", add_a, 32'h6);
    checkOutput("basic_res_valid_early", res_valid, 0);
    step();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("basic_res_valid", res_valid, 1);
    checkOutput("basic_result", result, 32'hD);
    checkOutput("basic_result_hi", result_hi, 0);
    checkOutput("basic_op_ready_done", op_ready, 0);
    drainResult();
    checkOutput("basic_idle_busy", busy, 0);
    checkOutput("basic_idle_res_valid", res_valid, 0);
    checkOutput("basic_result_kept", result, 32'hD);

    $display("[TB] max-carry five-operand job");
    startJob(3'd5, 1'b1);
    for (int i = 0; i < 4; i++) sendOp(32'hFFFFFFFF);
    checkOutput("max_res_valid_after4", res_valid, 0);
    sendOp(32'hFFFFFFFF);
    checkOutput("max_res_valid", res_valid, 1);
    checkOutput("max_result", result, 32'hFFFFFFFC);
    checkOutput("max_result_hi", result_hi, 4);
    drainResult();
    checkOutput("max_idle", busy, 0);

    $display("[TB] bubbles and backpressure");
    startJob(3'd3, 1'b0);
    sendOp(32'd1);
    step(); step();
    checkOutput("bub_op_ready", op_ready, 1);
    checkOutput("bub_res_valid", res_valid, 0);
    sendOp(32'd2);
    step(); step();
    sendOp(32'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_res_valid", res_valid, 1);
      checkOutput("bp_result", result, 32'd6);
      checkOutput("bp_result_hi", result_hi, 0);
      step();
    end
    checkOutput("bp_still_valid", res_valid, 1);
    drainResult();
    checkOutput("bp_idle_busy", busy, 0);
    checkOutput("bp_idle_res_valid", res_valid, 0);

    $display("[TB] illegal and ignored starts");
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("ill0_err", err, 1);
    checkOutput("ill0_busy", busy, 0);
    step();
    checkOutput("ill0_err_pulse", err, 0);
    applyStimulus(1'b1, 3'd6, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("ill6_err", err, 1);
    checkOutput("ill6_busy", busy, 0);
    startJob(3'd2, 1'b0);
    sendOp(32'd10);
    applyStimulus(1'b1, 3'd5, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("ign_err", err, 0);
    sendOp(32'd20);
    checkOutput("ign_res_valid", res_valid, 1);
    checkOutput("ign_result", result, 32'd30);
    drainResult();

    $display("[TB] abort mid-job");
    startJob(3'd4, 1'b0);
    sendOp(32'd1);
    sendOp(32'd2);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 32'd5, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_op_ready", op_ready, 0);
    checkOutput("abort_res_valid", res_valid, 0);
    step(); step();
    checkOutput("abort_res_valid_later", res_valid, 0);
    startJob(3'd1, 1'b0);
    sendOp(32'd9);
    checkOutput("abort_next_valid", res_valid, 1);
    checkOutput("abort_next_result", result, 32'd9);
    checkOutput("abort_next_hi", result_hi, 0);
    drainResult();

    $display("[TB] reset mid-job");
    startJob(3'd4, 1'b0);
    sendOp(32'd1);
    sendOp(32'd2);
    resetn = 1'b0;
    #1;
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_result", result, 0);
    step();
    resetn = 1'b1;
    step();
    checkOutput("rstmid_res_valid", res_valid, 0);
    startJob(3'd1, 1'b0);
    sendOp(32'd9);
    checkOutput("rstmid_next_valid", res_valid, 1);
    checkOutput("rstmid_next_result", result, 32'd9);
    drainResult();
    checkOutput("rstmid_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
Sequencer that time-shares one external 32-bit two-input adder (a/b/cin -> result/cout) to sum a stream of 1..MAX_OPS operands plus an initial carry-in. It is the multi-operand add path for the lab datapath: operands arrive one per cycle over a valid/ready handshake. The result is returned with its extended carry bits, so the full multi-operand sum is never truncated.

Parameters:
MAX_OPS, 5, maximum operands per job (1..7)
CW, 3, width of result_hi carry accumulator; must hold MAX_OPS-1

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  job request pulse, sampled in IDLE only
num_ops  input  3  operand count for this job, sampled with start
cin  input  1  job carry-in, sampled with start
abort  input  1  synchronous job cancel
op_valid  input  1  operand valid
op_ready  output  1  controller accepts operand
op_data  input  32  operand
add_a  output  32  to shared adder operand A
add_b  output  32  to shared adder operand B
add_cin  output  1  to shared adder carry-in
add_result  input  32  from shared adder (combinational, same cycle)
add_cout  input  1  from shared adder
res_valid  output  1  result available
res_ready  input  1  result consumer ready
result  output  32  low 32 bits of total sum
result_hi  output  CW  carries above bit 31
busy  output  1  state != IDLE
err  output  1  one-cycle pulse on illegal start

Behaviour:
- Reset (resetn=0, async): state=IDLE; acc, hi, remaining, cin_l, first cleared; op_ready=0, res_valid=0, result=0, result_hi=0, busy=0, err=0.
- States: IDLE, ACCUM, DONE.
- IDLE: op_ready=0. start=1 with 1<=num_ops<=MAX_OPS: acc<=0, hi<=0, remaining<=num_ops, cin_l<=cin, first<=1, go to ACCUM. start with num_ops=0 or >MAX_OPS: err=1 for the next cycle, stay in IDLE.
- ACCUM: op_ready=1 (registered-state decode, not dependent on op_valid). add_a=acc, add_b=op_data, add_cin=first ? cin_l : 0.
- Transfer = op_valid & op_ready. On a transfer: acc<=add_result, hi<=hi+add_cout, first<=0, remaining<=remaining-1. If remaining==1, go to DONE.
- ACCUM with op_valid=0: no state change; any number of bubbles is allowed.
- Outside ACCUM: add_a=acc, add_b=0, add_cin=0.
- Throughput is one operand per cycle. res_valid rises the cycle after the last transfer.
- DONE: res_valid=1, result=acc, result_hi=hi. Both are held stable until res_ready=1. On res_valid & res_ready, go to IDLE the next cycle; result and result_hi keep their last values.
- start outside IDLE is ignored: no err, and num_ops/cin are not resampled.
- abort=1 in ACCUM or DONE: go to IDLE the next cycle, res_valid=0, partial sum discarded. abort has priority over transfer and the res handshake. abort in IDLE has no effect, and also wins over start in the same cycle.
- Arithmetic: {result_hi,result} = cin + sum of operands, exact. hi addition wraps modulo 2^CW; it never overflows with legal parameters.
- resetn asserted mid-job: immediate return to reset values; the job is lost.

Test Plan:
- Reset: hold resetn=0, toggle start/op_valid -> all outputs 0, busy=0. After release: op_ready=0, res_valid=0.
- Basic: start, num_ops=2, cin=1, ops 0x5 then 0x7 back-to-back -> add_cin=1 on first transfer only. res_valid one cycle after 2nd op, result=0x0000000D, result_hi=0.
- Max carry: num_ops=5, cin=1, five ops 0xFFFFFFFF -> result=0xFFFFFFFC, result_hi=4. Total latency 5 transfer cycles + 1.
- Backpressure/bubbles: num_ops=3, ops 1,2,3 with op_valid low 2 cycles between each, res_ready low 3 cycles -> result=6 held stable throughout. Returns to IDLE the cycle after res_ready.
- Illegal/ignored: start with num_ops=0 -> err one cycle, busy stays 0. num_ops=6 -> err. start during ACCUM -> ignored, job completes with the original count.
- Abort/reset mid-job: num_ops=4, abort after 2 transfers -> IDLE next cycle, res_valid never asserted, and the next job (num_ops=1, op 9, cin=0) returns 9. Repeat with resetn pulsed low instead of abort -> same recovery.
